mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Round-robin arbiter and access sequencer for the 16x2 memory module. It shares the memory's single address/data/write-enable port between NREQ requesters. Each requester issues a read or write via a req/ack handshake. The arbiter latches the winning request, drives the memory for one access cycle, then returns an ack with the read data. It sits between the requester blocks (generator/testbench agents, future masters) and the memory.

Parameters:
NREQ, 2, number of requesters (2..8)
AW, 4, memory address width
DW, 2, memory data width

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
req  input  NREQ  per-requester request; level, held until ack
req_we  input  NREQ  per-requester op: 1=write, 0=read
req_addr  input  NREQ*AW  packed addresses; requester i at [i*AW +: AW]
req_wdata  input  NREQ*DW  packed write data; requester i at [i*DW +: DW]
gnt  output  NREQ  one-hot; requester currently being served
ack  output  NREQ  one-hot, one-cycle pulse on completion
rdata  output  DW  read data; valid in the ack cycle of a read
mem_addr  output  AW  address to memory
mem_wdata  output  DW  write data to memory
mem_wr_en  output  1  memory write enable; memory writes on posedge while high
mem_rdata  input  DW  combinational read data from memory at mem_addr

Behaviour:
- Reset values: state=IDLE; gnt=0, ack=0, rdata=0, mem_addr=0, mem_wdata=0, mem_wr_en=0; round-robin pointer last=NREQ-1, so requester 0 wins first.
- Sync reset: on any cycle with rst=1, all of the above are restored at that edge. A transaction in flight is abandoned and no ack is issued. If rst coincides with ACCESS of a write, the memory may still capture that edge; the arbiter makes no guarantee about it.
- FSM has three states: IDLE -> ACCESS -> ACK -> IDLE.
- IDLE: if req != 0, select the winner w as the first set bit searching (last+1) mod NREQ upward with wrap. Latch addr, wdata, we of w, set gnt[w], set last=w, and go to ACCESS. If req=0, stay in IDLE with all memory outputs 0.
- ACCESS (exactly 1 cycle): mem_addr=latched addr, mem_wdata=latched wdata, mem_wr_en=latched we. At the end of this cycle rdata <= mem_rdata (captured for reads; left unchanged for writes). Go to ACK.
- ACK (1 cycle): ack[w]=1, gnt[w] held, mem_wr_en=0, mem_addr and mem_wdata return to 0. Go to IDLE and clear gnt.
- Latency is 2 cycles from the IDLE edge that samples req to the ack pulse. Throughput is at most one access per 3 cycles.
- Requester rules:
  - addr/wdata/we must be stable while req=1 until ack.
  - The requester samples ack and drops req at the next edge unless it issues a back-to-back request.
  - A req still high in the cycle after ack is treated as a new request.
- Req deasserted during ACCESS/ACK: the transaction still completes and ack is still pulsed, because the request was latched.
- Simultaneous requests: round-robin guarantees no requester waits more than NREQ-1 transactions.
- gnt and ack are always one-hot or zero. mem_wr_en is never high outside ACCESS.

Decomposition:
- Package mem_pkg holds AW/DW defaults, the FSM state enum (IDLE, ACCESS, ACK), and the rr_pick function (round-robin first-set search).
- One natural sub-module is rr_arbiter (req, last pointer -> one-hot winner), purely combinational and reusable. The FSM and latches stay in mem_arbiter.

Test Plan:
- Reset, then req=2'b00 for 10 cycles -> mem_wr_en=0, gnt=0, ack=0 throughout, mem_addr=0.
- Req0 writes addr=4'h3, wdata=2'b10 -> exactly one mem_wr_en cycle with mem_addr=3, mem_wdata=2; ack[0] 2 cycles after req sampled. Then req0 reads addr 3 -> ack[0] with rdata=2'b10.
- req=2'b11 held continuously, both reads -> grants alternate 0,1,0,1; ack sequence matches; each ack 3 cycles apart.
- Req1 writes addr=4'hF, wdata=2'b01, and req1 drops req during ACCESS -> write completes, ack[1] still pulses, memory[15]=1.
- rst=1 during ACCESS of a read by req0 -> next cycle state IDLE, gnt=0, no ack[0]. After release, req0 re-wins and completes.
- Write addr 0 = 2'b11, then read addr 0 by the other requester -> rdata=2'b11 (cross-requester coherency through the shared memory).

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the 16x2 memory arbiter.
package mem_pkg;

    localparam int AW_DEF   = 4;
    localparam int DW_DEF   = 2;
    // The round-robin search works on a fixed 8-wide vector; callers zero-pad.
    localparam int RR_MAX   = 8;
    localparam int RR_IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    // One-hot pick of the first set bit of req[0..n-1], starting at last+1 and wrapping.
    function automatic logic [RR_MAX-1:0] rr_pick(
        input logic [RR_MAX-1:0]   req,
        input logic [RR_IDX_W-1:0] last,
        input int                  n
    );
        logic [RR_MAX-1:0]   pick;
        logic                found;
        int                  idx;
        logic [RR_IDX_W-1:0] bidx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= RR_MAX; k++) begin
            idx  = (int'(last) + k) % n;
            bidx = idx[RR_IDX_W-1:0];
            if ((k <= n) && !found && req[bidx]) begin
                found      = 1'b1;
                pick[bidx] = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: request vector plus last winner -> one-hot winner.
module rr_arbiter
    import mem_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int LW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [LW-1:0]   last,
    output logic [NREQ-1:0] winner
);

    logic [RR_MAX-1:0]   w_req_pad;
    logic [RR_IDX_W-1:0] w_last_pad;
    logic [RR_MAX-1:0]   w_pick;

    assign w_req_pad  = RR_MAX'(req);
    assign w_last_pad = RR_IDX_W'(last);
    assign w_pick     = rr_pick(w_req_pad, w_last_pad, NREQ);
    assign winner     = w_pick[NREQ-1:0];

    // Upper pick bits are always zero because the padded requests are zero.
    generate
        if (NREQ < RR_MAX) begin : g_pad
            logic w_unused_hi;
            assign w_unused_hi = |w_pick[RR_MAX-1:NREQ];
        end
    endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and single-access sequencer sharing one memory port among NREQ requesters.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    ack,
    output logic [DW-1:0]      rdata,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    output logic               mem_wr_en,
    input  logic [DW-1:0]      mem_rdata
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            r_state;
    logic [NREQ-1:0]   r_gnt;
    logic [NREQ-1:0]   r_ack;
    logic [DW-1:0]     r_rdata;
    logic [LW-1:0]     r_last;
    // The memory-facing registers double as the latched request: they are
    // loaded on the grant edge and hold through the single ACCESS cycle.
    logic [AW-1:0]     r_mem_addr;
    logic [DW-1:0]     r_mem_wdata;
    logic              r_mem_wr_en;

    logic [NREQ-1:0]   w_winner;
    logic [LW-1:0]     w_idx;
    logic [AW-1:0]     w_sel_addr;
    logic [DW-1:0]     w_sel_wdata;
    logic              w_sel_we;

    rr_arbiter #(
        .NREQ (NREQ),
        .LW   (LW)
    ) u_rr (
        .req    (req),
        .last   (r_last),
        .winner (w_winner)
    );

    // Decode the one-hot winner into an index and mux out its request fields.
    always_comb begin
        w_idx       = '0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_we    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winner[i]) begin
                w_idx       = LW'(i);
                w_sel_addr  = req_addr[i*AW +: AW];
                w_sel_wdata = req_wdata[i*DW +: DW];
                w_sel_we    = req_we[i];
            end
        end
    end

    // Access sequencer: IDLE grants and latches, ACCESS drives the memory, ACK pulses completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_ack       <= '0;
            r_rdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wr_en <= 1'b0;
            r_last      <= LW'(NREQ - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    r_ack <= '0;
                    if (|req) begin
                        r_gnt       <= w_winner;
                        r_last      <= w_idx;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                        r_mem_wr_en <= w_sel_we;
                        r_state     <= ACCESS;
                    end else begin
                        r_gnt       <= '0;
                        r_mem_addr  <= '0;
                        r_mem_wdata <= '0;
                        r_mem_wr_en <= 1'b0;
                    end
                end
                ACCESS: begin
                    // Reads capture the combinational memory output; writes leave rdata alone.
                    if (!r_mem_wr_en) begin
                        r_rdata <= mem_rdata;
                    end
                    r_ack       <= r_gnt;
                    r_mem_addr  <= '0;
                    r_mem_wdata <= '0;
                    r_mem_wr_en <= 1'b0;
                    r_state     <= ACK;
                end
                ACK: begin
                    r_ack   <= '0;
                    r_gnt   <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign ack       = r_ack;
    assign rdata     = r_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wr_en = r_mem_wr_en;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 16x2 memory model behind it.
module tb_mem_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 4;
    localparam int DW   = 2;

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic [DW-1:0]      rdata;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic               mem_wr_en;
    logic [DW-1:0]      mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // 16x2 memory: combinational read, write on posedge while enabled.
    logic [DW-1:0] mem [0:15] = '{default: 2'b00};
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .ack       (ack),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wr_en (mem_wr_en),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        tick(); tick();
        n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL rst_gnt: got %b want 00", gnt); end
        n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL rst_ack: got %b want 00", ack); end
        n_checks++; if (rdata !== 2'b00) begin n_fail++; $display("FAIL rst_rdata: got %b want 00", rdata); end
        n_checks++; if (mem_addr !== 4'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
        n_checks++; if (mem_wdata !== 2'b00) begin n_fail++; $display("FAIL rst_wdata: got %b want 00", mem_wdata); end
        n_checks++; if (mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en: got %b want 0", mem_wr_en); end
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_checks++;
            if (mem_wr_en !== 1'b0 || gnt !== 2'b00 || ack !== 2'b00 || mem_addr !== 4'h0) begin
                n_fail++;
                $display("FAIL idle_quiet cycle %0d: wr_en=%b gnt=%b ack=%b addr=%h want 0/00/00/0",
                         c, mem_wr_en, gnt, ack, mem_addr);
            end
        end
    endtask

    task automatic test_write_read();
        // Requester 0 writes 2'b10 to address 3.
        req_we = 2'b01; req_addr = {4'h0, 4'h3}; req_wdata = {2'b00, 2'b10}; req = 2'b01;
        tick();
        n_checks++; if (mem_wr_en !== 1'b1) begin n_fail++; $display("FAIL wr_access_en: got %b want 1", mem_wr_en); end
        n_checks++; if (mem_addr !== 4'h3) begin n_fail++; $display("FAIL wr_access_addr: got %h want 3", mem_addr); end
        n_checks++; if (mem_wdata !== 2'b10) begin n_fail++; $display("FAIL wr_access_wdata: got %b want 10", mem_wdata); end
        n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL wr_access_gnt: got %b want 01", gnt); end
        n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL wr_access_ack: got %b want 00", ack); end
        tick();
        n_checks++; if (ack !== 2'b01) begin n_fail++; $display("FAIL wr_ack: got %b want 01", ack); end
        n_checks++; if (mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL wr_ack_en: got %b want 0", mem_wr_en); end
        n_checks++; if (mem_addr !== 4'h0) begin n_fail++; $display("FAIL wr_ack_addr: got %h want 0", mem_addr); end
        n_checks++; if (mem[3] !== 2'b10) begin n_fail++; $display("FAIL wr_mem3: got %b want 10", mem[3]); end
        req = 2'b00;
        tick();
        n_checks++; if (ack !== 2'b00 || gnt !== 2'b00) begin n_fail++; $display("FAIL wr_done: ack=%b gnt=%b want 00/00", ack, gnt); end
        // Requester 0 reads address 3 back.
        req_we = 2'b00; req = 2'b01;
        tick();
        n_checks++; if (mem_wr_en !== 1'b0 || mem_addr !== 4'h3) begin n_fail++; $display("FAIL rd_access: wr_en=%b addr=%h want 0/3", mem_wr_en, mem_addr); end
        tick();
        n_checks++; if (ack !== 2'b01) begin n_fail++; $display("FAIL rd_ack: got %b want 01", ack); end
        n_checks++; if (rdata !== 2'b10) begin n_fail++; $display("FAIL rd_data: got %b want 10", rdata); end
        req = 2'b00;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_gnt [1:12];
        logic [1:0] exp_ack [1:12];
        logic [1:0] exp_rd  [1:12];
        // Requester 0 won last, so requester 1 goes first. r0 reads addr 3 (10), r1 reads addr 0 (00).
        exp_gnt = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00};
        exp_ack = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00};
        exp_rd  = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10};
        req_we = 2'b00; req_addr = {4'h0, 4'h3}; req_wdata = '0; req = 2'b11;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_checks++;
            if (gnt !== exp_gnt[k] || ack !== exp_ack[k] || rdata !== exp_rd[k] || mem_wr_en !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_cycle %0d: gnt=%b ack=%b rdata=%b wr_en=%b want %b/%b/%b/0",
                         k, gnt, ack, rdata, mem_wr_en, exp_gnt[k], exp_ack[k], exp_rd[k]);
            end
        end
        req = 2'b00;
        tick();
    endtask

    task automatic test_drop_during_access();
        // Requester 1 writes 2'b01 to address 15 and withdraws req once granted.
        req_we = 2'b10; req_addr = {4'hF, 4'h0}; req_wdata = {2'b01, 2'b00}; req = 2'b10;
        tick();
        n_checks++;
        if (gnt !== 2'b10 || mem_wr_en !== 1'b1 || mem_addr !== 4'hF || mem_wdata !== 2'b01) begin
            n_fail++;
            $display("FAIL drop_access: gnt=%b wr_en=%b addr=%h wdata=%b want 10/1/f/01",
                     gnt, mem_wr_en, mem_addr, mem_wdata);
        end
        req = 2'b00;
        tick();
        n_checks++; if (ack !== 2'b10) begin n_fail++; $display("FAIL drop_ack: got %b want 10", ack); end
        n_checks++; if (mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL drop_ack_en: got %b want 0", mem_wr_en); end
        tick();
        n_checks++; if (mem[15] !== 2'b01) begin n_fail++; $display("FAIL drop_mem15: got %b want 01", mem[15]); end
        n_checks++; if (ack !== 2'b00 || gnt !== 2'b00) begin n_fail++; $display("FAIL drop_idle: ack=%b gnt=%b want 00/00", ack, gnt); end
    endtask

    task automatic test_reset_in_access();
        // Requester 0 reads address 3; reset lands during its ACCESS cycle.
        req_we = 2'b00; req_addr = {4'h0, 4'h3}; req_wdata = '0; req = 2'b01;
        tick();
        n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL rsta_gnt: got %b want 01", gnt); end
        rst = 1'b1;
        tick();
        n_checks++;
        if (gnt !== 2'b00 || ack !== 2'b00 || mem_wr_en !== 1'b0 || mem_addr !== 4'h0 || rdata !== 2'b00) begin
            n_fail++;
            $display("FAIL rsta_abandon: gnt=%b ack=%b wr_en=%b addr=%h rdata=%b want 00/00/0/0/00",
                     gnt, ack, mem_wr_en, mem_addr, rdata);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (gnt !== 2'b01 || ack !== 2'b00 || mem_addr !== 4'h3) begin
            n_fail++;
            $display("FAIL rsta_regrant: gnt=%b ack=%b addr=%h want 01/00/3", gnt, ack, mem_addr);
        end
        tick();
        n_checks++;
        if (ack !== 2'b01 || rdata !== 2'b10) begin
            n_fail++;
            $display("FAIL rsta_complete: ack=%b rdata=%b want 01/10", ack, rdata);
        end
        req = 2'b00;
        tick();
    endtask

    task automatic test_coherency();
        // Requester 0 writes 2'b11 to address 0; requester 1 then reads it.
        req_we = 2'b01; req_addr = {4'h0, 4'h0}; req_wdata = {2'b00, 2'b11}; req = 2'b01;
        tick();
        n_checks++;
        if (gnt !== 2'b01 || mem_wr_en !== 1'b1 || mem_wdata !== 2'b11) begin
            n_fail++;
            $display("FAIL coh_write: gnt=%b wr_en=%b wdata=%b want 01/1/11", gnt, mem_wr_en, mem_wdata);
        end
        tick();
        n_checks++; if (ack !== 2'b01) begin n_fail++; $display("FAIL coh_wack: got %b want 01", ack); end
        req = 2'b00;
        tick();
        req_we = 2'b00; req = 2'b10;
        tick();
        n_checks++; if (gnt !== 2'b10 || mem_addr !== 4'h0) begin n_fail++; $display("FAIL coh_rgnt: gnt=%b addr=%h want 10/0", gnt, mem_addr); end
        tick();
        n_checks++; if (ack !== 2'b10) begin n_fail++; $display("FAIL coh_rack: got %b want 10", ack); end
        n_checks++; if (rdata !== 2'b11) begin n_fail++; $display("FAIL coh_rdata: got %b want 11", rdata); end
        req = 2'b00;
        tick();
    endtask

    initial begin
        rst = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_drop_during_access();
        test_reset_in_access();
        test_coherency();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
